// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A clock divider produces the pixel strobe p_tick. Horizontal and vertical
// counters step on p_tick and run through active, front porch, sync and back
// porch. Sync, blanking and marker outputs are registered from the next counter
// values, so they always describe the position shown on x/y.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // The divider needs at least one bit even when CLK_DIV is 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [XW-1:0] h_cnt;
  logic [XW-1:0] h_next;
  logic [YW-1:0] v_cnt;
  logic [YW-1:0] v_next;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_on;
  logic          vs_on;
  logic          vis_next;

  // The strobe is decoded from the divider register; enable is the only
  // combinational input, so freezing takes effect in the same clk.
  assign p_tick = enable && (div_cnt == DIV_LAST);

  // Position outputs are the counter registers themselves.
  assign x = h_cnt;
  assign y = v_cnt;

  // Divider: counts 0..CLK_DIV-1 while enabled, holds otherwise.
  // NOTE: state registers use <= so every flop samples pre-edge values; = here
  // would make the result depend on block ordering in simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end
  end

  // Next raster position and the decodes the output registers load from it.
  // NOTE: every signal gets a value at the top of the block before any branch,
  // otherwise an untaken path would hold the old value and infer a latch.
  always_comb begin
    h_wrap = (int'(h_cnt) == H_TOTAL - 1);
    v_wrap = (int'(v_cnt) == V_TOTAL - 1);
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      h_next = h_wrap ? '0 : h_cnt + XW'(1);
      if (h_wrap) begin
        v_next = v_wrap ? '0 : v_cnt + YW'(1);
      end
    end
    hs_on    = (int'(h_next) >= HS_START) && (int'(h_next) < HS_END);
    vs_on    = (int'(v_next) >= VS_START) && (int'(v_next) < VS_END);
    vis_next = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
  end

  // Counters and registered outputs, all loaded on the same edge so the
  // outputs never lag the position. Markers are one-clk pulses that clear
  // whenever the edge is not a wrap (including while frozen).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      display_on  <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      display_on  <= vis_next;
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      line_start  <= p_tick && h_wrap;
      frame_start <= p_tick && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. Four instances share
// clk/reset/enable: default timing, the tiny 8x6 raster at CLK_DIV=1 with
// active-high sync, the same raster at CLK_DIV=3, and default horizontal
// timing with a short 8-line frame for the mid-frame reset case.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic enable;

  int n_checks;
  int n_fail;

  // Default instance
  logic       def_p_tick, def_hsync, def_vsync, def_disp, def_ls, def_fs;
  logic [9:0] def_x, def_y;
  // Tiny raster, CLK_DIV=1, SYNC_POL=1
  logic       sm_p_tick, sm_hsync, sm_vsync, sm_disp, sm_ls, sm_fs;
  logic [2:0] sm_x, sm_y;
  // Tiny raster, CLK_DIV=3, SYNC_POL=1
  logic       d3_p_tick, d3_hsync, d3_vsync, d3_disp, d3_ls, d3_fs;
  logic [2:0] d3_x, d3_y;
  // Default horizontal, 8-line frame, CLK_DIV=1
  logic       md_p_tick, md_hsync, md_vsync, md_disp, md_ls, md_fs;
  logic [9:0] md_x, md_y;

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(def_p_tick),
    .hsync(def_hsync), .vsync(def_vsync), .display_on(def_disp),
    .x(def_x), .y(def_y), .line_start(def_ls), .frame_start(def_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b1), .XW(3), .YW(3)
  ) u_small (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(sm_p_tick),
    .hsync(sm_hsync), .vsync(sm_vsync), .display_on(sm_disp),
    .x(sm_x), .y(sm_y), .line_start(sm_ls), .frame_start(sm_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(3), .SYNC_POL(1'b1), .XW(3), .YW(3)
  ) u_div3 (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(d3_p_tick),
    .hsync(d3_hsync), .vsync(d3_vsync), .display_on(d3_disp),
    .x(d3_x), .y(d3_y), .line_start(d3_ls), .frame_start(d3_fs)
  );

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1)
  ) u_mid (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(md_p_tick),
    .hsync(md_hsync), .vsync(md_vsync), .display_on(md_disp),
    .x(md_x), .y(md_y), .line_start(md_ls), .frame_start(md_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clk and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across one rising edge; on return the bench sits in clk
  // cycle 0 after release with enable high.
  task automatic apply_reset();
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset  = 1'b1;
    enable = 1'b1;
    #3;  // before the first clk edge: values come from the asynchronous reset
    // {p_tick, hsync, vsync, display_on, line_start, frame_start}
    got = {def_p_tick, def_hsync, def_vsync, def_disp, def_ls, def_fs};
    n_checks++;
    if (got !== 6'b011100) begin
      n_fail++;
      $display("FAIL reset_def_flags: got %b expected %b", got, 6'b011100);
    end
    n_checks++;
    if ({def_x, def_y} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_def_xy: got x=%0d y=%0d expected 0,0", def_x, def_y);
    end
    // Active-high sync idles low; CLK_DIV=1 makes p_tick follow enable.
    got = {sm_p_tick, sm_hsync, sm_vsync, sm_disp, sm_ls, sm_fs};
    n_checks++;
    if (got !== 6'b100100) begin
      n_fail++;
      $display("FAIL reset_small_flags: got %b expected %b", got, 6'b100100);
    end
    n_checks++;
    if (d3_p_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_div3_ptick: got %b expected 0", d3_p_tick);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_pixel_tick();
    int first_tick;
    int bad;
    logic [9:0] ex;
    apply_reset();
    first_tick = -1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (def_p_tick === 1'b1 && first_tick < 0) first_tick = c;
      if (def_p_tick !== ((c % 2) == 1)) bad++;
      ex = 10'(c / 2);
      if (def_x !== ex) bad++;
      step();
    end
    n_checks++;
    if (first_tick !== 1) begin
      n_fail++;
      $display("FAIL first_ptick_cycle: got %0d expected 1", first_tick);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ptick_every_2nd: %0d mismatching cycles, expected 0", bad);
    end
  endtask

  task automatic test_hsync_line();
    int low_cnt, first_low_x, ls1, ls2, ls_cnt, bad;
    int px;
    logic [9:0] ex, ey;
    apply_reset();
    low_cnt = 0; first_low_x = -1; ls1 = -1; ls2 = -1; ls_cnt = 0; bad = 0;
    for (int c = 0; c <= 3201; c++) begin
      px = (c / 2) % 800;
      ex = 10'(px);
      ey = 10'(c / 1600);
      if (def_x !== ex || def_y !== ey) bad++;
      if (def_hsync !== !(px >= 656 && px < 752)) bad++;
      if (def_disp !== (px < 640)) bad++;
      if (def_vsync !== 1'b1) bad++;
      if (c < 1600 && def_p_tick === 1'b1 && def_hsync === 1'b0) begin
        low_cnt++;
        if (first_low_x < 0) first_low_x = int'(def_x);
      end
      if (def_ls === 1'b1) begin
        ls_cnt++;
        if (ls1 < 0) ls1 = c;
        else if (ls2 < 0) ls2 = c;
      end
      step();
    end
    n_checks++;
    if (low_cnt !== 96) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d ticks low expected 96", low_cnt);
    end
    n_checks++;
    if (first_low_x !== 656) begin
      n_fail++;
      $display("FAIL hsync_start_x: got %0d expected 656", first_low_x);
    end
    n_checks++;
    if (ls1 !== 1600 || ls2 !== 3200 || ls_cnt !== 2) begin
      n_fail++;
      $display("FAIL line_start_period: got cycles %0d,%0d count %0d expected 1600,3200 count 2",
               ls1, ls2, ls_cnt);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL line_raster: %0d mismatches on x/y/hsync/vsync/display_on, expected 0", bad);
    end
  endtask

  task automatic test_enable_freeze();
    int bad;
    int found;
    logic [9:0] ex;
    apply_reset();
    for (int c = 0; c < 200; c++) step();
    n_checks++;
    if (def_x !== 10'd100) begin
      n_fail++;
      $display("FAIL freeze_setup_x: got %0d expected 100", def_x);
    end
    enable = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (def_x !== 10'd100 || def_y !== 10'd0 || def_p_tick !== 1'b0) bad++;
      if (def_hsync !== 1'b1 || def_vsync !== 1'b1 || def_disp !== 1'b1) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL freeze_hold: %0d mismatching cycles, expected 0", bad);
    end
    enable = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      ex = 10'(100 + i / 2);
      if (def_x !== ex || def_p_tick !== ((i % 2) == 1)) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL freeze_resume: %0d mismatching cycles, expected 0", bad);
    end
    // Freeze while line_start is high: it must clear after one clk.
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      if (def_ls === 1'b1) found = 1;
      else step();
    end
    n_checks++;
    if (found !== 1) begin
      n_fail++;
      $display("FAIL freeze_ls_timeout: line_start not seen within 2000 clk");
    end else begin
      enable = 1'b0;
      #1;
      step();
      n_checks++;
      if (def_ls !== 1'b0 || def_x !== 10'd0 || def_y !== 10'd1) begin
        n_fail++;
        $display("FAIL freeze_ls_clear: got ls=%b x=%0d y=%0d expected 0,0,1",
                 def_ls, def_x, def_y);
      end
      enable = 1'b1;
    end
  endtask

  task automatic test_small_frame();
    int bad_xy, bad_sync, bad_disp, bad_mark, disp_cnt, fs_cnt;
    int px, py;
    logic [2:0] ex, ey;
    apply_reset();
    bad_xy = 0; bad_sync = 0; bad_disp = 0; bad_mark = 0; disp_cnt = 0; fs_cnt = 0;
    for (int c = 0; c <= 96; c++) begin
      px = c % 8;
      py = (c / 8) % 6;
      ex = 3'(px);
      ey = 3'(py);
      if (sm_x !== ex || sm_y !== ey) bad_xy++;
      if (sm_hsync !== (px == 5 || px == 6) || sm_vsync !== (py == 4)) bad_sync++;
      if (sm_disp !== (px < 4 && py < 3)) bad_disp++;
      if (sm_ls !== (c > 0 && c % 8 == 0) || sm_fs !== (c > 0 && c % 48 == 0)) bad_mark++;
      if (c < 48 && sm_disp === 1'b1) disp_cnt++;
      if (sm_fs === 1'b1) fs_cnt++;
      step();
    end
    n_checks++;
    if (bad_xy !== 0) begin
      n_fail++;
      $display("FAIL small_xy: %0d mismatching cycles, expected 0", bad_xy);
    end
    n_checks++;
    if (bad_sync !== 0) begin
      n_fail++;
      $display("FAIL small_sync: %0d mismatching cycles, expected 0", bad_sync);
    end
    n_checks++;
    if (bad_disp !== 0 || disp_cnt !== 12) begin
      n_fail++;
      $display("FAIL small_display_on: %0d mismatches, %0d visible pixels, expected 0 and 12",
               bad_disp, disp_cnt);
    end
    n_checks++;
    if (bad_mark !== 0 || fs_cnt !== 2) begin
      n_fail++;
      $display("FAIL small_markers: %0d mismatches, %0d frame_starts, expected 0 and 2",
               bad_mark, fs_cnt);
    end
  endtask

  task automatic test_div3();
    int bad, ticks, first_tick;
    int px, py;
    logic [2:0] ex, ey;
    apply_reset();
    bad = 0; ticks = 0; first_tick = -1;
    for (int c = 0; c <= 150; c++) begin
      px = (c / 3) % 8;
      py = (c / 24) % 6;
      ex = 3'(px);
      ey = 3'(py);
      if (d3_p_tick !== ((c % 3) == 2)) bad++;
      if (d3_x !== ex || d3_y !== ey) bad++;
      if (d3_hsync !== (px == 5 || px == 6) || d3_vsync !== (py == 4)) bad++;
      if (d3_disp !== (px < 4 && py < 3)) bad++;
      if (d3_ls !== (c > 0 && c % 24 == 0) || d3_fs !== (c == 144)) bad++;
      if (d3_p_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = c;
      end
      step();
    end
    n_checks++;
    if (first_tick !== 2 || ticks !== 50) begin
      n_fail++;
      $display("FAIL div3_ptick: first at %0d, %0d ticks, expected 2 and 50", first_tick, ticks);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL div3_raster: %0d mismatches, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 4700; c++) step();
    n_checks++;
    if (md_x !== 10'd700 || md_y !== 10'd5 || md_hsync !== 1'b0 || md_vsync !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_setup: got x=%0d y=%0d hs=%b vs=%b expected 700,5,0,0",
               md_x, md_y, md_hsync, md_vsync);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (md_x !== 10'd0 || md_y !== 10'd0 || md_hsync !== 1'b1 || md_vsync !== 1'b1 ||
        md_disp !== 1'b1 || md_ls !== 1'b0 || md_fs !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b disp=%b ls=%b fs=%b expected 0,0,1,1,1,0,0",
               md_x, md_y, md_hsync, md_vsync, md_disp, md_ls, md_fs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    enable   = 1'b1;
    test_reset();
    test_pixel_tick();
    test_hsync_line();
    test_enable_freeze();
    test_small_frame();
    test_div3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
